bus_sequencer: RTL and testbench

Sequential stage directly downstream of the combinational CPU bus interface. It accepts one word-aligned, byte-strobed read or write at a time and decodes it into one of three regions: ROM, RAM or IO. It drives the region with the programmed wait states, or waits on the IO ready handshake, and returns read data with a one-cycle completion pulse to the CPU. Alignment errors from upstream, decode errors and IO timeouts are all reported as bus errors on the same completion pulse.

---
 rtl/bus_sequencer_if.sv | 43 ++++
 rtl/bus_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// Bus bundle between the CPU bus interface, the sequencer and the memory regions.
// Requests: businterface_address / data_out / data_strobes / read / write / bus_error.
// Completion: businterface_data_in, seq_ready, seq_bus_error.
// Region side: mem_select, mem_address, mem_data_out, mem_data_strobes,
//              mem_read, mem_write, mem_data_in, io_ready.
// Modports: master = the sequencer, slave = CPU/region environment.
interface bus_sequencer_if;
    logic [29:0] businterface_address;
    logic [31:0] businterface_data_out;
    logic [3:0]  businterface_data_strobes;
    logic        businterface_read;
    logic        businterface_write;
    logic        businterface_bus_error;
    logic [31:0] businterface_data_in;
    logic        seq_ready;
    logic        seq_bus_error;
    logic [2:0]  mem_select;
    logic [29:0] mem_address;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_data_strobes;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_in;
    logic        io_ready;

    modport master (
        input  businterface_address, businterface_data_out, businterface_data_strobes,
        input  businterface_read, businterface_write, businterface_bus_error,
        input  mem_data_in, io_ready,
        output businterface_data_in, seq_ready, seq_bus_error,
        output mem_select, mem_address, mem_data_out, mem_data_strobes,
        output mem_read, mem_write
    );

    modport slave (
        output businterface_address, businterface_data_out, businterface_data_strobes,
        output businterface_read, businterface_write, businterface_bus_error,
        output mem_data_in, io_ready,
        input  businterface_data_in, seq_ready, seq_bus_error,
        input  mem_select, mem_address, mem_data_out, mem_data_strobes,
        input  mem_read, mem_write
    );
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: decodes one CPU access at a time into ROM / RAM / IO, holds the
// region strobes for the programmed wait states (or until io_ready), and returns
// read data with a one-cycle seq_ready pulse. Upstream misalignment, decode
// errors, ROM writes, read+write collisions and IO timeouts all complete with
// seq_bus_error=1 and data_in=ffffffff.
// Ports: clock, reset_n (async, active-low), bus (bus_sequencer_if.master).
// Optional feature: BUS_SEQUENCER_TIMEOUT_EN enables the IO_TIMEOUT counter;
// when undefined, IO accesses wait indefinitely for io_ready.
module bus_sequencer #(
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    bus_sequencer_if.master  bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SEL_W  = 3;

    localparam logic [CNT_W-1:0]  ROM_LOAD = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0]  RAM_LOAD = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0]  IO_LOAD  = CNT_W'(IO_TIMEOUT);
    localparam logic [DATA_W-1:0] ERR_DATA = '1;

    localparam logic [1:0] REGION_ROM = 2'b00;
    localparam logic [1:0] REGION_RAM = 2'b01;
    localparam logic [1:0] REGION_IO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                ready_q,  ready_d;
    logic                err_q,    err_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   dout_q,   dout_d;
    logic [STRB_W-1:0]   strb_q,   strb_d;
    logic                rd_q,     rd_d;
    logic                wr_q,     wr_d;

    logic [1:0]          region_c;
    logic                request_c;
    logic                decode_fail_c;
    logic                finish_c;
    logic                timeout_c;

    // Request decode: byte address bits [31:30] are word address bits [29:28].
    always_comb begin
        region_c      = bus.businterface_address[ADDR_W-1 -: 2];
        request_c     = bus.businterface_read | bus.businterface_write;
        decode_fail_c = bus.businterface_bus_error
                      | (region_c == 2'b11)
                      | ((region_c == REGION_ROM) & bus.businterface_write)
                      | (bus.businterface_read & bus.businterface_write);
    end

    // Access completion: wait-state expiry for ROM/RAM, io_ready (or timeout) for IO.
    always_comb begin
        finish_c  = 1'b0;
        timeout_c = 1'b0;
        if (state_q == ACCESS) begin
            if (sel_q[2]) begin
                if (bus.io_ready) begin
                    finish_c = 1'b1;
                end
`ifdef BUS_SEQUENCER_TIMEOUT_EN
                else if (count_q == '0) begin
                    timeout_c = 1'b1;
                end
`endif
            end else if (count_q == '0) begin
                finish_c = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is a register below.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        data_in_d = data_in_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        sel_d     = sel_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        strb_d    = strb_q;
        rd_d      = rd_q;
        wr_d      = wr_q;

        unique case (state_q)
            IDLE: begin
                if (request_c) begin
                    if (decode_fail_c) begin
                        state_d   = DONE;
                        ready_d   = 1'b1;
                        err_d     = 1'b1;
                        data_in_d = ERR_DATA;
                    end else begin
                        state_d = ACCESS;
                        addr_d  = bus.businterface_address;
                        dout_d  = bus.businterface_data_out;
                        strb_d  = bus.businterface_data_strobes;
                        rd_d    = bus.businterface_read;
                        wr_d    = bus.businterface_write;
                        unique case (region_c)
                            REGION_ROM: begin
                                sel_d   = 3'b001;
                                count_d = ROM_LOAD;
                            end
                            REGION_RAM: begin
                                sel_d   = 3'b010;
                                count_d = RAM_LOAD;
                            end
                            REGION_IO: begin
                                sel_d   = 3'b100;
                                count_d = IO_LOAD;
                            end
                            default: begin
                                sel_d   = '0;
                                count_d = '0;
                            end
                        endcase
                    end
                end
            end

            ACCESS: begin
                if (finish_c || timeout_c) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    sel_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    count_d = '0;
                    if (timeout_c) begin
                        err_d     = 1'b1;
                        data_in_d = ERR_DATA;
                    end else if (rd_q) begin
                        data_in_d = bus.mem_data_in;
                    end
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears strobes without waiting for an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            data_in_q <= ERR_DATA;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            strb_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            data_in_q <= data_in_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            strb_q    <= strb_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
        end
    end

    assign bus.businterface_data_in = data_in_q;
    assign bus.seq_ready            = ready_q;
    assign bus.seq_bus_error        = err_q;
    assign bus.mem_select           = sel_q;
    assign bus.mem_address          = addr_q;
    assign bus.mem_data_out         = dout_q;
    assign bus.mem_data_strobes     = strb_q;
    assign bus.mem_read             = rd_q;
    assign bus.mem_write            = wr_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios followed by random
// transactions, each predicted from the access rules (region, error conditions,
// wait states, IO handshake) rather than from the RTL structure.
module tb_bus_sequencer;

    localparam int unsigned ROM_W  = 1;
    localparam int unsigned RAM_W  = 0;
    localparam int unsigned IO_TO  = 15;
    localparam int          BOUND  = 60;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    bus_sequencer_if bus();

    bus_sequencer #(
        .ROM_WAIT   (ROM_W),
        .RAM_WAIT   (RAM_W),
        .IO_TIMEOUT (IO_TO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_data = 32'hffffffff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.businterface_read      = 1'b0;
        bus.businterface_write     = 1'b0;
        bus.businterface_bus_error = 1'b0;
        bus.io_ready               = 1'b0;
    endtask

    // One transaction: predict outcome, drive request, observe until seq_ready.
    task automatic run_txn(input logic [31:0] baddr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic rd, input logic wr,
                           input logic berr, input int io_delay, input logic [31:0] din,
                           input string name);
        logic [1:0] region;
        logic       fail;
        logic       exp_err;
        logic [2:0] exp_sel;
        int         w;
        int         exp_lat;
        int         exp_strobe;
        int         n;
        int         strobe_cycles;
        logic [2:0] sel_first;
        logic       rd_first;
        logic       wr_first;
        logic       timed_out;

        region  = baddr[31:30];
        fail    = berr || (region == 2'b11) || (wr && region == 2'b00) || (rd && wr);
        exp_err = fail;
        exp_sel = fail ? 3'b000 : (3'b001 << region);
        if (fail) begin
            exp_lat    = 1;
            exp_strobe = 0;
            model_data = 32'hffffffff;
        end else if (region != 2'b10) begin
            w          = (region == 2'b00) ? int'(ROM_W) : int'(RAM_W);
            exp_lat    = w + 2;
            exp_strobe = w + 1;
            if (rd) model_data = din;
        end else begin
`ifdef BUS_SEQUENCER_TIMEOUT_EN
            if (io_delay > int'(IO_TO)) begin
                exp_lat    = int'(IO_TO) + 2;
                exp_strobe = int'(IO_TO) + 1;
                exp_err    = 1'b1;
                model_data = 32'hffffffff;
            end else
`endif
            begin
                exp_lat    = io_delay + 2;
                exp_strobe = io_delay + 1;
                if (rd) model_data = din;
            end
        end

        bus.businterface_address      = baddr[31:2];
        bus.businterface_data_out     = wdata;
        bus.businterface_data_strobes = strb;
        bus.businterface_read         = rd;
        bus.businterface_write        = wr;
        bus.businterface_bus_error    = berr;
        bus.mem_data_in               = din;
        bus.io_ready                  = 1'b0;

        n = 0;
        strobe_cycles = 0;
        timed_out = 1'b0;
        sel_first = '0;
        rd_first = 1'b0;
        wr_first = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) begin
                sel_first = bus.mem_select;
                rd_first  = bus.mem_read;
                wr_first  = bus.mem_write;
            end
            if (bus.seq_ready === 1'b1) break;
            if (bus.mem_read || bus.mem_write) strobe_cycles++;
            if (region == 2'b10 && (n - 1) >= io_delay) bus.io_ready = 1'b1;
            if (n > BOUND) begin
                timed_out = 1'b1;
                break;
            end
        end
        chk({name, "_complete"}, 32'(timed_out), 32'd0);
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_strobe_cycles"}, 32'(strobe_cycles), 32'(exp_strobe));
        chk({name, "_sel"}, 32'(sel_first), 32'(exp_sel));
        chk({name, "_rd_wr"}, 32'({rd_first, wr_first}), 32'({~fail & rd, ~fail & wr}));
        chk({name, "_bus_error"}, 32'(bus.seq_bus_error), 32'(exp_err));
        chk({name, "_data_in"}, bus.businterface_data_in, model_data);
        chk({name, "_done_idle_strobes"}, 32'({bus.mem_select, bus.mem_read, bus.mem_write}), 32'd0);
        if (!fail) begin
            chk({name, "_mem_address"}, 32'(bus.mem_address), 32'(baddr[31:2]));
            chk({name, "_mem_data_out"}, bus.mem_data_out, wdata);
            chk({name, "_mem_strobes"}, 32'(bus.mem_data_strobes), 32'(strb));
        end

        clear_inputs();
        @(posedge clock);
        #1;
        chk({name, "_ready_clear"}, 32'({bus.seq_ready, bus.seq_bus_error}), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  reg_sel;
        int          kind;
        int          dly;
        int          cnt;

        clear_inputs();
        bus.businterface_address      = '0;
        bus.businterface_data_out     = '0;
        bus.businterface_data_strobes = '0;
        bus.mem_data_in               = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_data_in", bus.businterface_data_in, 32'hffffffff);
        chk("reset_ready_err", 32'({bus.seq_ready, bus.seq_bus_error}), 32'd0);
        chk("reset_mem_ctrl", 32'({bus.mem_select, bus.mem_read, bus.mem_write}), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_address), 32'd0);
        chk("reset_mem_dout", bus.mem_data_out, 32'd0);
        chk("reset_mem_strb", 32'(bus.mem_data_strobes), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_txn(32'h40000010, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 32'h12345678, "ram_read");
        run_txn(32'h00000000, 32'h55aa55aa, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 32'h0, "rom_write");
        run_txn(32'h40000003, 32'hffffffab, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 32'h0, "ram_byte_write");
        run_txn(32'h80000000, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 2, 32'h000000ab, "io_read");
        run_txn(32'hc0000000, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 32'h0, "unmapped");
        run_txn(32'h40000020, 32'h0, 4'b1111, 1'b1, 1'b1, 1'b0, 0, 32'h0, "rd_and_wr");
        run_txn(32'h40000024, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b1, 0, 32'h0, "upstream_err");
        run_txn(32'h00000040, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 32'hcafef00d, "rom_read");
        run_txn(32'h80000008, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, int'(IO_TO), 32'h0badc0de, "io_last_cycle");

`ifdef BUS_SEQUENCER_TIMEOUT_EN
        run_txn(32'h80000004, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 1000, 32'h11111111, "io_timeout");
`else
        // IO never answers: no completion for 100 cycles, then io_ready releases it.
        bus.businterface_address      = 30'h20000001;
        bus.businterface_data_strobes = 4'b1111;
        bus.businterface_read         = 1'b1;
        bus.mem_data_in               = 32'h2468ace0;
        cnt = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (bus.seq_ready) cnt++;
        end
        chk("io_wait_no_ready", 32'(cnt), 32'd0);
        chk("io_wait_strobe", 32'({bus.mem_select, bus.mem_read}), 32'b1001);
        bus.io_ready = 1'b1;
        cnt = 0;
        while (!bus.seq_ready && cnt < 5) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("io_wait_release_latency", 32'(cnt), 32'd1);
        chk("io_wait_error", 32'(bus.seq_bus_error), 32'd0);
        model_data = 32'h2468ace0;
        chk("io_wait_data", bus.businterface_data_in, model_data);
        clear_inputs();
        @(posedge clock);
        #1;
`endif

        // Reset in the middle of a ROM read drops everything asynchronously.
        bus.businterface_address      = 30'h00000040;
        bus.businterface_data_strobes = 4'b1111;
        bus.businterface_read         = 1'b1;
        bus.mem_data_in               = 32'h77777777;
        @(posedge clock);
        #1;
        @(posedge clock);
        #2;
        chk("pre_reset_active", 32'({bus.mem_select, bus.mem_read}), 32'b0011);
        reset_n = 1'b0;
        #1;
        chk("async_reset_ctrl", 32'({bus.mem_select, bus.mem_read, bus.mem_write, bus.seq_ready}), 32'd0);
        chk("async_reset_addr", 32'(bus.mem_address), 32'd0);
        clear_inputs();
        model_data = 32'hffffffff;
        chk("async_reset_data_in", bus.businterface_data_in, model_data);
        @(posedge clock);
        #1;
        chk("reset_held_no_ready", 32'(bus.seq_ready), 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_txn(32'h40000100, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 32'h89abcdef, "post_reset_ram");

        // Random traffic against the rule-based prediction.
        for (int i = 0; i < 40; i++) begin
            reg_sel = 2'($urandom_range(0, 3));
            a = {reg_sel, 30'($urandom)};
            kind = int'($urandom_range(0, 9));
`ifdef BUS_SEQUENCER_TIMEOUT_EN
            dly = int'($urandom_range(0, 20));
`else
            dly = int'($urandom_range(0, 12));
`endif
            run_txn(a, $urandom, 4'($urandom), (kind != 0 && kind <= 5) || kind == 0,
                    kind == 0 || kind > 5, ($urandom_range(0, 11) == 0), dly, $urandom,
                    $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
